// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg                                                               |
// | Shared command encoding and sizing helpers for the PC/stack unit.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_pkg;

  // Listed in descending priority after CMD_NONE.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_RET  = 3'd1,
    CMD_CALL = 3'd2,
    CMD_LD   = 3'd3,
    CMD_BR   = 3'd4,
    CMD_INC  = 3'd5
  } cmd_e;

  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_stack_unit_if                                                     |
// | Control-unit to PC/stack unit command and status bundle.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pc_stack_unit_if #(
  parameter int DATAWIDTH   = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = pc_pkg::sp_width(STACK_DEPTH);

  logic [DATAWIDTH-1:0] data_in;
  logic [DATAWIDTH-1:0] offset;
  logic                 ld_pc;
  logic                 br_pc;
  logic                 inc_pc;
  logic                 call;
  logic                 ret;
  logic                 err_clr;
  logic [DATAWIDTH-1:0] count;
  logic [SP_W-1:0]      sp;
  logic                 stack_empty;
  logic                 stack_full;
  logic                 ovf;
  logic                 unf;

  modport master (
    output data_in, offset, ld_pc, br_pc, inc_pc, call, ret, err_clr,
    input  count, sp, stack_empty, stack_full, ovf, unf
  );

  modport slave (
    input  data_in, offset, ld_pc, br_pc, inc_pc, call, ret, err_clr,
    output count, sp, stack_empty, stack_full, ovf, unf
  );

endinterface
`default_nettype wire

// File: rtl/pc_stack_unit_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | return_stack                                                         |
// | Parametrised LIFO of return addresses with guarded push/pop.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module return_stack #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int SP_W      = pc_pkg::sp_width(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 clr,
  input  wire logic                 push,
  input  wire logic                 pop,
  input  wire logic [DATAWIDTH-1:0] push_data,
  output logic [DATAWIDTH-1:0]      top,
  output logic [SP_W-1:0]           sp,
  output logic                      full,
  output logic                      empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] c_depth = SP_W'(DEPTH);

  // Storage rounded up to a power of two so sp slices index it directly;
  // entries at or above DEPTH are never written.
  logic [DATAWIDTH-1:0] r_mem [0:(2**IDX_W)-1];
  logic [SP_W-1:0]      r_sp;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [IDX_W-1:0]     w_rd_idx;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_sp == c_depth);
  assign empty     = (r_sp == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && !pop && !full;
  assign w_wr_idx  = r_sp[IDX_W-1:0];
  assign w_rd_idx  = w_wr_idx - IDX_W'(1);
  assign top       = r_mem[w_rd_idx];
  assign sp        = r_sp;

  // Contents deliberately survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SP_W'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_stack_unit                                                        |
// | Program counter with relative branch, call/return stack and flags.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int                   DATAWIDTH    = 8,
  parameter int                   STACK_DEPTH  = 4,
  parameter logic [DATAWIDTH-1:0] RESET_VECTOR = '0
) (
  input  wire logic     clk,
  input  wire logic     clr,
  pc_stack_unit_if.slave bus
);

  localparam int SP_W = sp_width(STACK_DEPTH);

  cmd_e                 w_cmd;
  logic [DATAWIDTH-1:0] r_count;
  logic [DATAWIDTH-1:0] w_count_nxt;
  logic [DATAWIDTH-1:0] w_inc;
  logic [DATAWIDTH-1:0] w_br;
  logic [DATAWIDTH-1:0] w_top;
  logic [SP_W-1:0]      w_sp;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 w_ovf_set;
  logic                 w_unf_set;

  always_comb begin
    w_cmd = CMD_NONE;
    if (bus.ret)         w_cmd = CMD_RET;
    else if (bus.call)   w_cmd = CMD_CALL;
    else if (bus.ld_pc)  w_cmd = CMD_LD;
    else if (bus.br_pc)  w_cmd = CMD_BR;
    else if (bus.inc_pc) w_cmd = CMD_INC;
  end

  // Modular add covers signed offsets; truncation gives the wrap.
  assign w_inc     = r_count + DATAWIDTH'(1);
  assign w_br      = r_count + bus.offset;
  assign w_push    = (w_cmd == CMD_CALL);
  assign w_pop     = (w_cmd == CMD_RET);
  assign w_ovf_set = w_push && w_full;
  assign w_unf_set = w_pop && w_empty;

  always_comb begin
    w_count_nxt = r_count;
    case (w_cmd)
      CMD_RET:  if (!w_empty) w_count_nxt = w_top;
      CMD_CALL: if (!w_full)  w_count_nxt = bus.data_in;
      CMD_LD:   w_count_nxt = bus.data_in;
      CMD_BR:   w_count_nxt = w_br;
      CMD_INC:  w_count_nxt = w_inc;
      default:  w_count_nxt = r_count;
    endcase
  end

  return_stack #(
    .DATAWIDTH (DATAWIDTH),
    .DEPTH     (STACK_DEPTH),
    .SP_W      (SP_W)
  ) u_stack (
    .clk       (clk),
    .clr       (clr),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_inc),
    .top       (w_top),
    .sp        (w_sp),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count <= RESET_VECTOR;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~bus.err_clr);
      r_unf   <= w_unf_set | (r_unf & ~bus.err_clr);
    end
  end

  assign bus.count       = r_count;
  assign bus.sp          = w_sp;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.ovf         = r_ovf;
  assign bus.unf         = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_stack_unit                                                     |
// | Directed vector bench for pc_stack_unit (DATAWIDTH 8, depth 3).     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc_stack_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int SPW   = $clog2(DEPTH + 1);

  // Control word order: {ret, call, ld_pc, br_pc, inc_pc, err_clr}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RET  = 6'b100000;
  localparam logic [5:0] CALL = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] BR   = 6'b000100;
  localparam logic [5:0] INC  = 6'b000010;
  localparam logic [5:0] ECLR = 6'b000001;

  typedef struct {
    string           name;
    logic [5:0]      ctl;
    logic [DW-1:0]   din;
    logic [DW-1:0]   off;
    logic [DW-1:0]   e_cnt;
    logic [SPW-1:0]  e_sp;
    logic            e_ovf;
    logic            e_unf;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_stack_unit_if #(.DATAWIDTH(DW), .STACK_DEPTH(DEPTH)) bus ();

  pc_stack_unit #(
    .DATAWIDTH    (DW),
    .STACK_DEPTH  (DEPTH),
    .RESET_VECTOR (8'h00)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic add(input string n, input logic [5:0] ctl, input logic [DW-1:0] din,
                     input logic [DW-1:0] off, input logic [DW-1:0] cnt, input int s,
                     input logic ov, input logic un);
    vec_t v;
    v.name = n; v.ctl = ctl; v.din = din; v.off = off;
    v.e_cnt = cnt; v.e_sp = SPW'(s); v.e_ovf = ov; v.e_unf = un;
    tv.push_back(v);
  endtask

  task automatic drive(input logic [5:0] ctl, input logic [DW-1:0] din, input logic [DW-1:0] off);
    {bus.ret, bus.call, bus.ld_pc, bus.br_pc, bus.inc_pc, bus.err_clr} = ctl;
    bus.data_in = din;
    bus.offset  = off;
  endtask

  task automatic check(input string n, input logic [DW-1:0] cnt, input logic [SPW-1:0] s,
                       input logic ov, input logic un);
    logic [DW+SPW+3:0] act;
    logic [DW+SPW+3:0] exp;
    act = {bus.count, bus.sp, bus.stack_empty, bus.stack_full, bus.ovf, bus.unf};
    exp = {cnt, s, (s == SPW'(0)), (s == SPW'(DEPTH)), ov, un};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {count,sp,empty,full,ovf,unf}=%h expected %h", n, act, exp);
    end
  endtask

  task automatic step(input string n, input logic [5:0] ctl, input logic [DW-1:0] din,
                      input logic [DW-1:0] off, input logic [DW-1:0] cnt, input int s,
                      input logic ov, input logic un);
    @(negedge clk);
    drive(ctl, din, off);
    @(posedge clk);
    #1;
    check(n, cnt, SPW'(s), ov, un);
  endtask

  initial begin
    //  name                ctl               din    off    count  sp ovf unf
    add("ld_40",            LD,               8'h40, 8'h00, 8'h40, 0, 0, 0);
    add("br_minus4",        BR,               8'h00, 8'hFC, 8'h3C, 0, 0, 0);
    add("br_plus16",        BR,               8'h00, 8'h10, 8'h4C, 0, 0, 0);
    add("ld_fe",            LD,               8'hFE, 8'h00, 8'hFE, 0, 0, 0);
    add("br_wrap_up",       BR,               8'h00, 8'h05, 8'h03, 0, 0, 0);
    add("ld_10",            LD,               8'h10, 8'h00, 8'h10, 0, 0, 0);
    add("call_20",          CALL,             8'h20, 8'h00, 8'h20, 1, 0, 0);
    add("call_30_with_inc", CALL|INC,         8'h30, 8'h00, 8'h30, 2, 0, 0);
    add("ret_first",        RET,              8'h00, 8'h00, 8'h21, 1, 0, 0);
    add("ret_second",       RET,              8'h00, 8'h00, 8'h11, 0, 0, 0);
    add("ld_54",            LD,               8'h54, 8'h00, 8'h54, 0, 0, 0);
    add("call_60",          CALL,             8'h60, 8'h00, 8'h60, 1, 0, 0);
    add("prio_ret",         RET|CALL|LD|INC,  8'h99, 8'h00, 8'h55, 0, 0, 0);
    add("prio_ld",          LD|BR|INC,        8'h77, 8'h05, 8'h77, 0, 0, 0);
    add("prio_br",          BR|INC,           8'h00, 8'h02, 8'h79, 0, 0, 0);
    add("inc",              INC,              8'h00, 8'h00, 8'h7A, 0, 0, 0);
    add("idle_hold",        NONE,             8'hAA, 8'h33, 8'h7A, 0, 0, 0);
    add("ret_empty",        RET,              8'h00, 8'h00, 8'h7A, 0, 0, 1);
    add("set_beats_clear",  RET|ECLR,         8'h00, 8'h00, 8'h7A, 0, 0, 1);
    add("err_clr_unf",      ECLR,             8'h00, 8'h00, 8'h7A, 0, 0, 0);
    add("br_wrap_up2",      BR,               8'h00, 8'h86, 8'h00, 0, 0, 0);
    add("br_wrap_down",     BR,               8'h00, 8'hFF, 8'hFF, 0, 0, 0);
    add("inc_wrap",         INC,              8'h00, 8'h00, 8'h00, 0, 0, 0);
    add("fill_1",           CALL,             8'h10, 8'h00, 8'h10, 1, 0, 0);
    add("fill_2",           CALL,             8'h20, 8'h00, 8'h20, 2, 0, 0);
    add("fill_3",           CALL,             8'h30, 8'h00, 8'h30, 3, 0, 0);
    add("call_when_full",   CALL,             8'h99, 8'h00, 8'h30, 3, 1, 0);
    add("pop_a",            RET,              8'h00, 8'h00, 8'h21, 2, 1, 0);
    add("pop_b",            RET,              8'h00, 8'h00, 8'h11, 1, 1, 0);
    add("pop_c",            RET,              8'h00, 8'h00, 8'h01, 0, 1, 0);
    add("pop_extra",        RET,              8'h00, 8'h00, 8'h01, 0, 1, 1);
    add("err_clr_both",     ECLR,             8'h00, 8'h00, 8'h01, 0, 0, 0);

    clr = 1'b1;
    drive(NONE, 8'h00, 8'h00);
    @(negedge clk);
    check("reset_state", 8'h00, SPW'(0), 1'b0, 1'b0);
    clr = 1'b0;

    for (int i = 0; i < 256; i++) begin
      step($sformatf("inc_%0d", i), INC, 8'h00, 8'h00, DW'(i + 1), 0, 1'b0, 1'b0);
    end

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].name, tv[i].ctl, tv[i].din, tv[i].off, tv[i].e_cnt, int'(tv[i].e_sp),
           tv[i].e_ovf, tv[i].e_unf);
    end

    // Async clear with two return addresses live.
    step("pre_ld_10",   LD,   8'h10, 8'h00, 8'h10, 0, 1'b0, 1'b0);
    step("pre_call_20", CALL, 8'h20, 8'h00, 8'h20, 1, 1'b0, 1'b0);
    step("pre_ld_32",   LD,   8'h32, 8'h00, 8'h32, 1, 1'b0, 1'b0);
    step("pre_call_33", CALL, 8'h33, 8'h00, 8'h33, 2, 1'b0, 1'b0);
    @(negedge clk);
    drive(NONE, 8'h00, 8'h00);
    #2 clr = 1'b1;
    #1 check("async_clr_mid_cycle", 8'h00, SPW'(0), 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    step("ret_after_clr", RET,  8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1);
    step("stale_unreach", RET,  8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
